// File: rtl/net_router_pkg.sv
// Shared definitions for the ring-router output-port unit.
// Provides port index constants, the default message width and a one-hot rotate helper.
package net_router_pkg;

    localparam int NET_WEST      = 2;
    localparam int NET_TERM      = 1;
    localparam int NET_EAST      = 0;
    localparam int NET_MSG_NBITS = 44;

    // Rotate a 3-bit one-hot vector left by one: bit0->bit1->bit2->bit0.
    function automatic logic [2:0] rotl3(input logic [2:0] v);
        return {v[1:0], v[2]};
    endfunction

endpackage

// File: rtl/net_rr_arb3.sv
// Three-way round-robin arbiter with a registered one-hot priority pointer.
// Ports: clk, reset_n (async active-low), en (grant enable), reqs[2:0], grants[2:0].
module net_rr_arb3
    import net_router_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [2:0] reqs,
    output logic [2:0] grants
);

    logic [2:0] ptr;

    // Scan upward from the pointer bit, wrapping bit2 -> bit0.
    always_comb begin
        grants = 3'b000;
        if (en) begin
            unique case (1'b1)
                ptr[0]: begin
                    if      (reqs[0]) grants = 3'b001;
                    else if (reqs[1]) grants = 3'b010;
                    else if (reqs[2]) grants = 3'b100;
                end
                ptr[1]: begin
                    if      (reqs[1]) grants = 3'b010;
                    else if (reqs[2]) grants = 3'b100;
                    else if (reqs[0]) grants = 3'b001;
                end
                ptr[2]: begin
                    if      (reqs[2]) grants = 3'b100;
                    else if (reqs[0]) grants = 3'b001;
                    else if (reqs[1]) grants = 3'b010;
                end
                default: grants = 3'b000;
            endcase
        end
    end

    // The winner drops to lowest priority next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= 3'b001;
        else if (|grants)
            ptr <= rotl3(grants);
    end

endmodule

// File: rtl/net_router_output_ctrl.sv
// Ring-router output port: round-robin grant over west/terminal/east, output FIFO, val/rdy link.
// Ports: clk, reset_n, reqs/grants (bit2 W, bit1 T, bit0 E), in_msg_w/t/e, out_val/out_rdy/out_msg, num_free.
// Optional same-cycle empty-queue bypass enabled by macro NET_ROUTER_OUTPUT_CTRL_BYPASS_EN.
module net_router_output_ctrl
    import net_router_pkg::*;
#(
    parameter  int p_msg_nbits      = NET_MSG_NBITS,
    parameter  int p_num_entries    = 4,
    localparam int c_num_free_nbits = $clog2(p_num_entries + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [2:0]                  reqs,
    output logic [2:0]                  grants,
    input  logic [p_msg_nbits-1:0]      in_msg_w,
    input  logic [p_msg_nbits-1:0]      in_msg_t,
    input  logic [p_msg_nbits-1:0]      in_msg_e,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [p_msg_nbits-1:0]      out_msg,
    output logic [c_num_free_nbits-1:0] num_free
);

    localparam int IW = $clog2(p_num_entries);
    localparam int CW = c_num_free_nbits;

    localparam logic [IW-1:0] LAST_IDX = IW'(p_num_entries - 1);
    localparam logic [CW-1:0] DEPTH    = CW'(p_num_entries);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [p_msg_nbits-1:0] mem [p_num_entries];
    logic [IW-1:0]          head;
    logic [IW-1:0]          tail;
    logic [CW-1:0]          count;

    logic                   full;
    logic                   empty;
    logic                   bypass;
    logic                   enq;
    logic                   deq;
    logic [p_msg_nbits-1:0] enq_msg;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);

    net_rr_arb3 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (!full),
        .reqs    (reqs),
        .grants  (grants)
    );

    always_comb begin
        enq_msg = '0;
        unique case (1'b1)
            grants[NET_WEST]: enq_msg = in_msg_w;
            grants[NET_TERM]: enq_msg = in_msg_t;
            grants[NET_EAST]: enq_msg = in_msg_e;
            default:          enq_msg = '0;
        endcase
    end

`ifdef NET_ROUTER_OUTPUT_CTRL_BYPASS_EN
    // Empty queue and ready sink: the granted message skips storage.
    assign bypass = empty && (|grants) && out_rdy;
`else
    assign bypass = 1'b0;
`endif

    assign enq      = (|grants) && !bypass;
    assign deq      = !empty && out_rdy;
    assign out_val  = !empty || bypass;
    assign out_msg  = bypass ? enq_msg : mem[head];
    assign num_free = DEPTH - count;

    always_ff @(posedge clk) begin
        if (enq)
            mem[tail] <= enq_msg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
            if (deq)
                head <= (head == LAST_IDX) ? '0 : head + 1'b1;
            if (enq && !deq)
                count <= count + ONE;
            else if (deq && !enq)
                count <= count - ONE;
        end
    end

endmodule
